// File: rtl/aes128_dec_key_sched_pkg.sv
// Shared definitions for the AES-128 decryption key schedule:
// FSM encoding, round count, Rcon lookup and big-endian word/byte slicing.
package aes128_dec_key_sched_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_OUTPUT = 2'd2
    } state_e;

    // Round constant for rounds 1..10; anything else yields zero.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    // Word idx of a 128-bit block; word 0 sits in the most significant bits.
    function automatic logic [31:0] get_word(input logic [127:0] blk, input int idx);
        return blk[127 - 32*idx -: 32];
    endfunction

    // Byte idx of a word; byte 0 sits in the most significant bits.
    function automatic logic [7:0] get_byte(input logic [31:0] w, input int idx);
        return w[31 - 8*idx -: 8];
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes128_dec_key_sched_sbox_word.sv
// aes_sbox_word: four forward AES S-boxes applied bytewise to a 32-bit word.
// Pure combinational; shared with the encryption-side key schedules.
module aes_sbox_word (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x sits at the most significant end for x=0.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[2047 - 8*int'(x) -: 8];
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign word_o[8*g +: 8] = sbox(word_i[8*g +: 8]);
    end

endmodule

// File: rtl/aes128_dec_key_sched.sv
// aes128_dec_key_sched: decryption round-key generator for AES-128.
// Expands forward to round key 10, then walks back to round key 0 under a
// valid/next handshake using the inverse key-schedule recurrence.
// Build option: AES_DEC_KEY_CACHE_EN keeps rk10 in a cache so a restart with
// key_reuse_i can skip the forward expansion.
module aes128_dec_key_sched
    import aes128_dec_key_sched_pkg::*;
#(
    parameter logic [7:0] RCON_LAST = 8'h36
) (
    input  logic         clk_i,
    input  logic         arst_n_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic         key_reuse_i,
    input  logic         next_i,
    input  logic         key_destruct_i,
    output logic [127:0] key_o,
    output logic [3:0]   round_o,
    output logic         key_valid_o,
    output logic         done_o,
    output logic         ready_o
);

    if (RCON_LAST != rcon(4'd10)) begin : g_rcon_chk
        $error("RCON_LAST does not match the round-10 Rcon");
    end

    state_e         state_q, state_d;
    logic [127:0]   rk_q, rk_d;
    logic [3:0]     round_q, round_d;
    logic           vld_q, vld_d;
    logic           done_q, done_d;

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0]   cache_q, cache_d;
    logic           cache_vld_q, cache_vld_d;
`else
    logic           unused_reuse;
    assign unused_reuse = key_reuse_i;
`endif

    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    sub_in, sub_out, rc_word;
    logic [3:0]     rcon_idx;
    logic [127:0]   fwd_key, inv_key;
    logic [31:0]    f0, f1, f2, f3, p0, p1, p2, p3;

    assign w0 = get_word(rk_q, 0);
    assign w1 = get_word(rk_q, 1);
    assign w2 = get_word(rk_q, 2);
    assign w3 = get_word(rk_q, 3);

    // The one SubWord is shared: forward takes w3, inverse takes the
    // recovered previous w3 (w3^w2). Rcon index follows the same split.
    assign sub_in   = (state_q == ST_EXPAND) ? rot_word(w3) : rot_word(w3 ^ w2);
    assign rcon_idx = (state_q == ST_EXPAND) ? round_q + 4'd1 : round_q;
    assign rc_word  = {rcon(rcon_idx), 24'h0};

    aes_sbox_word u_sbox (
        .word_i (sub_in),
        .word_o (sub_out)
    );

    assign f0 = w0 ^ sub_out ^ rc_word;
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;
    assign fwd_key = {f0, f1, f2, f3};

    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;
    assign p0 = w0 ^ sub_out ^ rc_word;
    assign inv_key = {p0, p1, p2, p3};

    // The done cycle still counts as busy so a start there is dropped.
    assign ready_o     = (state_q == ST_IDLE) && !done_q;
    assign key_valid_o = vld_q;
    assign key_o       = vld_q ? rk_q : '0;
    assign round_o     = round_q;
    assign done_o      = done_q;

    // Next-state and datapath update; destruct overrides everything.
    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        round_d = round_q;
        vld_d   = vld_q;
        done_d  = 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
        cache_d     = cache_q;
        cache_vld_d = cache_vld_q;
`endif
        if (key_destruct_i) begin
            state_d = ST_IDLE;
            rk_d    = '0;
            round_d = '0;
            vld_d   = 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_d     = '0;
            cache_vld_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && ready_o) begin
`ifdef AES_DEC_KEY_CACHE_EN
                        if (key_reuse_i && cache_vld_q) begin
                            // rk10 lands now; valid follows one cycle later.
                            rk_d    = cache_q;
                            round_d = 4'(NUM_ROUNDS);
                            state_d = ST_OUTPUT;
                        end else
`endif
                        begin
                            rk_d    = key_i;
                            round_d = '0;
                            state_d = ST_EXPAND;
                        end
                    end
                end
                ST_EXPAND: begin
                    rk_d    = fwd_key;
                    round_d = round_q + 4'd1;
                    if (round_q == 4'(NUM_ROUNDS - 1)) begin
                        vld_d   = 1'b1;
                        state_d = ST_OUTPUT;
`ifdef AES_DEC_KEY_CACHE_EN
                        cache_d     = fwd_key;
                        cache_vld_d = 1'b1;
`endif
                    end
                end
                ST_OUTPUT: begin
`ifdef AES_DEC_KEY_CACHE_EN
                    if (!vld_q) vld_d = 1'b1;
                    else
`endif
                    if (next_i && vld_q) begin
                        if (round_q == 4'd0) begin
                            vld_d   = 1'b0;
                            done_d  = 1'b1;
                            rk_d    = '0;
                            state_d = ST_IDLE;
                        end else begin
                            rk_d    = inv_key;
                            round_d = round_q - 4'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and key registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ST_IDLE;
            rk_q    <= '0;
            round_q <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            round_q <= round_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

`ifdef AES_DEC_KEY_CACHE_EN
    // rk10 cache for key reuse.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cache_q     <= '0;
            cache_vld_q <= 1'b0;
        end else begin
            cache_q     <= cache_d;
            cache_vld_q <= cache_vld_d;
        end
    end
`endif

endmodule

// File: tb/tb_aes128_dec_key_sched.sv
// Testbench for aes128_dec_key_sched: random and known-answer keys, a
// FIPS-197 style forward expansion model, scoreboard checked on handshakes.
module tb_aes128_dec_key_sched;

    logic         clk_i = 1'b0;
    logic         arst_n_i = 1'b0;
    logic         start_i = 1'b0;
    logic [127:0] key_i = '0;
    logic         key_reuse_i = 1'b0;
    logic         next_i = 1'b0;
    logic         key_destruct_i = 1'b0;
    logic [127:0] key_o;
    logic [3:0]   round_o;
    logic         key_valid_o, done_o, ready_o;

    always #5 clk_i = ~clk_i;

    aes128_dec_key_sched dut (
        .clk_i          (clk_i),
        .arst_n_i       (arst_n_i),
        .start_i        (start_i),
        .key_i          (key_i),
        .key_reuse_i    (key_reuse_i),
        .next_i         (next_i),
        .key_destruct_i (key_destruct_i),
        .key_o          (key_o),
        .round_o        (round_o),
        .key_valid_o    (key_valid_o),
        .done_o         (done_o),
        .ready_o        (ready_o)
    );

    int errors = 0, checks = 0, done_cnt = 0, hs_cnt = 0;

    typedef struct packed {
        logic [3:0]   rnd;
        logic [127:0] key;
    } exp_t;
    exp_t         exp_q[$];
    exp_t         mon_e;
    logic [7:0]   sb[256];
    logic [127:0] rk_m[11];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v};
        return t[15 - n -: 8];
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Textbook word-array key expansion into rk_m[0..10].
    task automatic expand(input logic [127:0] key);
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every accepted handshake is compared with the scoreboard head.
    always @(negedge clk_i) begin
        if (done_o) done_cnt++;
        if (key_valid_o && next_i && arst_n_i && !key_destruct_i) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL handshake: unexpected key at round %0d", round_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("handshake round", 128'(round_o), 128'(mon_e.rnd));
                chk("handshake key", key_o, mon_e.key);
            end
        end
    end

    task automatic start_run(input string tag, input logic [127:0] key, input bit reuse,
                             input logic [127:0] model_key, input int exp_lat);
        int n;
        n = 0;
        while (!ready_o && n < 50) begin tick(); n++; end
        chk({tag, " ready before start"}, 128'(ready_o), 128'd1);
        expand(model_key);
        for (int r = 10; r >= 0; r--) exp_q.push_back({4'(r), rk_m[r]});
        start_i = 1'b1;
        key_i = key;
        key_reuse_i = reuse;
        tick();
        start_i = 1'b0;
        key_reuse_i = 1'b0;
        key_i = {$urandom(), $urandom(), $urandom(), $urandom()};
        n = 0;
        while (!key_valid_o && n < 30) begin tick(); n++; end
        chk({tag, " latency"}, 128'(n), 128'(exp_lat));
        chk({tag, " first round"}, 128'(round_o), 128'd10);
    endtask

    task automatic walk(input string tag, input int hold_rnd, input int hold_cyc,
                        input int destr_rnd, input bit rnd_next);
        int n, d0, h0;
        bit held, fin;
        n = 0; held = 0; fin = 0;
        d0 = done_cnt;
        h0 = hs_cnt;
        while (n < 400) begin
            if (done_o) begin fin = 1; break; end
            if (key_valid_o && destr_rnd >= 0 && int'(round_o) == destr_rnd) begin
                next_i = 1'b0;
                key_destruct_i = 1'b1;
                tick();
                key_destruct_i = 1'b0;
                chk({tag, " destruct key"}, key_o, '0);
                chk({tag, " destruct valid"}, 128'(key_valid_o), 128'd0);
                chk({tag, " destruct ready"}, 128'(ready_o), 128'd1);
                chk({tag, " destruct done"}, 128'(done_o), 128'd0);
                exp_q.delete();
                tick();
                chk({tag, " destruct no done"}, 128'(done_cnt), 128'(d0));
                return;
            end
            if (key_valid_o && !held && int'(round_o) == hold_rnd) begin
                held = 1;
                next_i = 1'b0;
                for (int k = 0; k < hold_cyc; k++) begin
                    start_i = 1'b1;
                    key_i = {$urandom(), $urandom(), $urandom(), $urandom()};
                    tick();
                    chk({tag, " hold key"}, key_o, rk_m[hold_rnd]);
                    chk({tag, " hold round"}, 128'(round_o), 128'(hold_rnd));
                    chk({tag, " hold ready"}, 128'(ready_o), 128'd0);
                end
                start_i = 1'b0;
            end
            next_i = rnd_next ? ($urandom_range(0, 2) != 0) : 1'b1;
            tick();
            n++;
        end
        next_i = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL %s walk: no done after %0d cycles", tag, n);
            return;
        end
        chk({tag, " ready in done cycle"}, 128'(ready_o), 128'd0);
        chk({tag, " key cleared"}, key_o, '0);
        chk({tag, " valid dropped"}, 128'(key_valid_o), 128'd0);
        start_i = 1'b1;
        key_i = {$urandom(), $urandom(), $urandom(), $urandom()};
        tick();
        start_i = 1'b0;
        chk({tag, " start in done cycle ignored"}, 128'(ready_o), 128'd1);
        chk({tag, " done one cycle"}, 128'(done_o), 128'd0);
        chk({tag, " done count"}, 128'(done_cnt - d0), 128'd1);
        chk({tag, " handshakes"}, 128'(hs_cnt - h0), 128'd11);
        chk({tag, " scoreboard drained"}, 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] fips, k, last;
        fips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        build_sbox();
        #1;
        chk("reset key_o", key_o, '0);
        chk("reset round_o", 128'(round_o), 128'd0);
        chk("reset valid", 128'(key_valid_o), 128'd0);
        chk("reset done", 128'(done_o), 128'd0);
        chk("reset ready", 128'(ready_o), 128'd1);
        @(negedge clk_i);
        arst_n_i = 1'b1;
        tick();

        // FIPS-197 key with back-pressure at round 7
        start_run("fips", fips, 1'b0, fips, 10);
        chk("fips rk10", key_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        walk("fips", 7, 5, -1, 1'b0);

        // Round 1 known answer via a hold
        start_run("fips2", fips, 1'b0, fips, 10);
        walk("fips2", 1, 1, -1, 1'b0);
        chk("fips rk1 model", rk_m[1], 128'ha0fafe1788542cb123a339392a6c7605);

        // Destruct mid-walk, then the same key again
        start_run("destr", fips, 1'b0, fips, 10);
        walk("destr", -1, 0, 4, 1'b0);
        start_run("after destr", fips, 1'b0, fips, 10);
        walk("after destr", -1, 0, -1, 1'b0);

        // Async reset during expansion
        start_i = 1'b1;
        key_i = fips;
        tick();
        start_i = 1'b0;
        repeat (5) tick();
        chk("expand round 5", 128'(round_o), 128'd5);
        chk("expand not ready", 128'(ready_o), 128'd0);
        #2 arst_n_i = 1'b0;
        #1;
        chk("async rst round", 128'(round_o), 128'd0);
        chk("async rst ready", 128'(ready_o), 128'd1);
        chk("async rst valid", 128'(key_valid_o), 128'd0);
        chk("async rst key", key_o, '0);
        @(negedge clk_i);
        arst_n_i = 1'b1;
        tick();
        k = {$urandom(), $urandom(), $urandom(), $urandom()};
        start_run("after rst", k, 1'b0, k, 10);
        walk("after rst", -1, 0, -1, 1'b1);

        // All-zero key
        start_run("zero", '0, 1'b0, '0, 10);
        chk("zero rk10", key_o, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        walk("zero", -1, 0, -1, 1'b0);

        // Random keys with random consumer stalls
        last = '0;
        for (int i = 0; i < 3; i++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            start_run("random", k, 1'b0, k, 10);
            walk("random", int'($urandom_range(1, 9)), 2, -1, 1'b1);
            last = k;
        end

        k = {$urandom(), $urandom(), $urandom(), $urandom()};
`ifdef AES_DEC_KEY_CACHE_EN
        start_run("reuse", k, 1'b1, last, 1);
        walk("reuse", -1, 0, -1, 1'b0);
        key_destruct_i = 1'b1;
        tick();
        key_destruct_i = 1'b0;
        start_run("reuse after destr", k, 1'b1, k, 10);
        walk("reuse after destr", -1, 0, -1, 1'b0);
`else
        start_run("reuse ignored", k, 1'b1, k, 10);
        walk("reuse ignored", -1, 0, -1, 1'b0);
`endif

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
